// File: rtl/adc_pkg.sv
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the ADC capture/decimation
//               block: FSM state encoding, ADC_control bit positions and
//               16-bit output saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // ADC_control bit positions (bits 3:2 are reserved)
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_SINGLE = 1;

    // Output sample range (16-bit two's complement)
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

endpackage

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
// ============================================================================
// Module      : axis_sync_fifo
// Description : Single-clock circular-buffer FIFO with full/empty flags.
//               The head entry is presented straight from the storage
//               registers. A write while full is accepted only when a read
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign do_rd    = rd_en && !empty;
    // When full, the slot being written is the one being freed by the read
    assign do_wr    = wr_en && (!full || do_rd);
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_capture_decim.sv
// ============================================================================
// Module      : adc_capture_decim
// Description : ADC capture with integrate-and-dump decimation, saturation
//               to 16 bits, pairing into 32-bit AXI-Stream beats, framing
//               with tlast and a sticky overflow flag for dropped beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_capture_decim
    import adc_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] ADC_data,
    input  logic              ADC_valid,
    input  logic [3:0]        ADC_control,
    input  logic [15:0]       Decim_ratio,
    input  logic [4:0]        Decim_shift,
    input  logic [15:0]       Frame_len,
    output logic              ADC_sleep,
    output logic              Overflow,
    output logic [31:0]       M_AXIS_tdata,
    output logic [3:0]        M_AXIS_tkeep,
    output logic              M_AXIS_tlast,
    output logic              M_AXIS_tvalid,
    input  logic              M_AXIS_tready
);

    localparam int ACC_W = DATA_W + 16;

    state_t                    state;
    state_t                    state_nx;
    logic [15:0]               ratio_q;
    logic [15:0]               flen_q;
    logic [4:0]                shift_q;
    logic                      single_q;
    logic signed [ACC_W-1:0]   acc;
    logic [15:0]               samp_cnt;
    logic [15:0]               dump_val;
    logic                      dump_vld;
    logic [15:0]               low_half;
    logic                      half_full;
    logic [15:0]               frame_cnt;
    logic                      overflow_q;

    logic                      enable;
    logic                      start;
    logic                      take;
    logic                      last_samp;
    logic                      push;
    logic                      beat_last;
    logic                      pop;
    logic                      drop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_valid;
    logic [32:0]               fifo_out;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   sum_next;
    logic signed [ACC_W-1:0]   shifted;
    logic [15:0]               sat_val;
    logic                      unused_ctrl;

    assign unused_ctrl = ^ADC_control[3:2] ^ fifo_empty;

    assign enable    = ADC_control[CTRL_ENABLE];
    assign start     = (state == IDLE) && enable;
    // Nothing is consumed or emitted on the cycle capture is being abandoned
    assign take      = (state == CAPTURE) && enable && ADC_valid;
    assign last_samp = (samp_cnt == ratio_q - 16'd1);
    assign push      = (state == CAPTURE) && enable && dump_vld && half_full;
    assign beat_last = (frame_cnt == flen_q - 16'd1);
    assign pop       = fifo_valid && M_AXIS_tready;
    assign drop      = push && fifo_full && !pop;

    // Offset binary to two's complement: flip the MSB, then sign-extend
    assign sample_ext = ACC_W'($signed({~ADC_data[DATA_W-1], ADC_data[DATA_W-2:0]}));

    // Running sum, arithmetic scaling and clamp to the 16-bit output range
    always_comb begin
        sum_next = acc + sample_ext;
        shifted  = sum_next >>> shift_q;
        if (shifted > ACC_W'(SAT_MAX)) begin
            sat_val = 16'(SAT_MAX);
        end else if (shifted < ACC_W'(SAT_MIN)) begin
            sat_val = 16'(SAT_MIN);
        end else begin
            sat_val = shifted[15:0];
        end
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; dropping enable always wins over completion
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable) state_nx = CAPTURE;
            end
            CAPTURE: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (push && beat_last && single_q) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!enable) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Config latch, decimator, pairing, frame counter and overflow flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ratio_q    <= 16'd1;
            flen_q     <= 16'd1;
            shift_q    <= '0;
            single_q   <= 1'b0;
            acc        <= '0;
            samp_cnt   <= '0;
            dump_val   <= '0;
            dump_vld   <= 1'b0;
            low_half   <= '0;
            half_full  <= 1'b0;
            frame_cnt  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (start) begin
                ratio_q    <= (Decim_ratio == 16'd0) ? 16'd1 : Decim_ratio;
                flen_q     <= (Frame_len == 16'd0) ? 16'd1 : Frame_len;
                shift_q    <= Decim_shift;
                single_q   <= ADC_control[CTRL_SINGLE];
                overflow_q <= 1'b0;
            end
            if (state != CAPTURE) begin
                // Outside capture all partial work is held cleared
                acc       <= '0;
                samp_cnt  <= '0;
                dump_vld  <= 1'b0;
                half_full <= 1'b0;
                frame_cnt <= '0;
            end else begin
                dump_vld <= take && last_samp;
                if (take) begin
                    if (last_samp) begin
                        acc      <= '0;
                        samp_cnt <= '0;
                        dump_val <= sat_val;
                    end else begin
                        acc      <= sum_next;
                        samp_cnt <= samp_cnt + 16'd1;
                    end
                end
                if (dump_vld) begin
                    if (half_full) begin
                        half_full <= 1'b0;
                    end else begin
                        low_half  <= dump_val;
                        half_full <= 1'b1;
                    end
                end
                // Dropped beats still advance the frame position
                if (push) begin
                    frame_cnt <= beat_last ? 16'd0 : frame_cnt + 16'd1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    axis_sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (push),
        .wr_data  ({beat_last, dump_val, low_half}),
        .rd_en    (M_AXIS_tready),
        .rd_data  (fifo_out),
        .rd_valid (fifo_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign M_AXIS_tdata  = fifo_out[31:0];
    assign M_AXIS_tlast  = fifo_out[32];
    assign M_AXIS_tvalid = fifo_valid;
    assign M_AXIS_tkeep  = 4'b1111;
    assign Overflow      = overflow_q;
    assign ADC_sleep     = (state != CAPTURE);

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_decim.sv
// ============================================================================
// Module      : tb_adc_capture_decim
// Description : Self-checking bench for adc_capture_decim with a
//               sample-list reference model of decimation, pairing and
//               framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_capture_decim;

    localparam int DATA_W     = 14;
    localparam int FIFO_DEPTH = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [DATA_W-1:0] ADC_data = '0;
    logic              ADC_valid = 1'b0;
    logic [3:0]        ADC_control = '0;
    logic [15:0]       Decim_ratio = 16'd1;
    logic [4:0]        Decim_shift = '0;
    logic [15:0]       Frame_len = 16'd1;
    logic              ADC_sleep;
    logic              Overflow;
    logic [31:0]       M_AXIS_tdata;
    logic [3:0]        M_AXIS_tkeep;
    logic              M_AXIS_tlast;
    logic              M_AXIS_tvalid;
    logic              M_AXIS_tready = 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [32:0] got_q[$];
    int          got_t[$];
    int          smp_q[$];
    logic [32:0] exp_q[$];
    int          hold_checks = 0;
    int          hold_viol = 0;
    bit          hold_pend = 1'b0;
    logic [32:0] hold_val = '0;
    bit          rnd_ready = 1'b0;

    adc_capture_decim #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ADC_data      (ADC_data),
        .ADC_valid     (ADC_valid),
        .ADC_control   (ADC_control),
        .Decim_ratio   (Decim_ratio),
        .Decim_shift   (Decim_shift),
        .Frame_len     (Frame_len),
        .ADC_sleep     (ADC_sleep),
        .Overflow      (Overflow),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tkeep  (M_AXIS_tkeep),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready)
    );

    always #5 aclk = ~aclk;

    // Beat collector and stall-stability watcher, sampled on the falling edge
    always @(negedge aclk) begin
        cyc = cyc + 1;
        if (M_AXIS_tvalid && M_AXIS_tready) begin
            got_q.push_back({M_AXIS_tlast, M_AXIS_tdata});
            got_t.push_back(cyc);
        end
        if (hold_pend && M_AXIS_tvalid) begin
            hold_checks = hold_checks + 1;
            if ({M_AXIS_tlast, M_AXIS_tdata} !== hold_val) hold_viol = hold_viol + 1;
        end
        hold_pend = M_AXIS_tvalid && !M_AXIS_tready;
        hold_val  = {M_AXIS_tlast, M_AXIS_tdata};
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference: group accepted samples into sums of R, scale, clamp, pair, frame
    function automatic void model_build(input int r, input int sh, input int fl, input bit single);
        int          r_eff  = (r == 0) ? 1 : r;
        int          fl_eff = (fl == 0) ? 1 : fl;
        longint      sum = 0;
        longint      v;
        int          n = 0;
        int          vals[$];
        int          idx;
        bit          last;
        logic [15:0] lo;
        logic [15:0] hi;
        exp_q.delete();
        foreach (smp_q[i]) begin
            sum = sum + longint'(smp_q[i]) - 64'sd8192;
            n   = n + 1;
            if (n == r_eff) begin
                v = sum >>> sh;
                if (v > 32767) v = 32767;
                else if (v < -32768) v = -32768;
                vals.push_back(int'(v));
                sum = 0;
                n   = 0;
            end
        end
        for (int k = 0; k + 1 < vals.size(); k += 2) begin
            idx  = k / 2 + 1;
            last = ((idx % fl_eff) == 0);
            lo   = 16'(vals[k]);
            hi   = 16'(vals[k+1]);
            exp_q.push_back({last, hi, lo});
            if (single && last) break;
        end
    endfunction

    task automatic start_capture(input int r, input int sh, input int fl, input bit single);
        Decim_ratio = 16'(r);
        Decim_shift = 5'(sh);
        Frame_len   = 16'(fl);
        ADC_valid   = 1'b0;
        ADC_control = {2'b00, single, 1'b1};
        @(posedge aclk); #1;
        // Configuration changes during capture must have no effect
        Decim_ratio = 16'($urandom);
        Decim_shift = 5'($urandom);
        Frame_len   = 16'($urandom);
        ADC_control = {2'($urandom), ~single, 1'b1};
    endtask

    task automatic stop_capture();
        ADC_control = 4'b0000;
        ADC_valid   = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end
    endtask

    task automatic feed(input int data, input bit valid);
        ADC_data  = DATA_W'(data);
        ADC_valid = valid;
        if (rnd_ready) M_AXIS_tready = ($urandom % 4) != 0;
        if (valid) smp_q.push_back(data);
        @(posedge aclk); #1;
    endtask

    task automatic idle_cycles(input int n);
        ADC_valid = 1'b0;
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", M_AXIS_tvalid); end
        checks++; if (M_AXIS_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", M_AXIS_tlast); end
        checks++; if (M_AXIS_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", M_AXIS_tdata); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
        checks++; if (ADC_sleep !== 1'b1) begin errors++; $display("FAIL reset_sleep: got %b want 1", ADC_sleep); end
        aresetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        checks++; if (M_AXIS_tkeep !== 4'hF) begin errors++; $display("FAIL tkeep: got %h want f", M_AXIS_tkeep); end
        checks++; if (ADC_sleep !== 1'b1) begin errors++; $display("FAIL idle_sleep: got %b want 1", ADC_sleep); end
    endtask

    // Ratio 0 and frame length 0 both behave as 1
    task automatic test_pack();
        got_q.delete(); smp_q.delete();
        start_capture(0, 0, 0, 1'b0);
        checks++; if (ADC_sleep !== 1'b0) begin errors++; $display("FAIL capture_sleep: got %b want 0", ADC_sleep); end
        feed(14'h3FFF, 1'b1);
        feed(14'h0000, 1'b1);
        idle_cycles(8);
        checks++;
        if (got_q.size() !== 1) begin errors++; $display("FAIL pack_count: got %0d beats want 1", got_q.size()); end
        else if (got_q[0] !== {1'b1, 16'hE000, 16'h1FFF}) begin
            errors++; $display("FAIL pack_data: got %h want %h", got_q[0], {1'b1, 16'hE000, 16'h1FFF});
        end
        stop_capture();
    endtask

    task automatic test_midscale_stream();
        got_q.delete(); got_t.delete(); smp_q.delete();
        start_capture(4, 2, 3, 1'b0);
        for (int i = 0; i < 48; i++) feed(14'h2000, 1'b1);
        idle_cycles(10);
        model_build(4, 2, 3, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] - got_t[i-1] !== 8) begin errors++; $display("FAIL stream_spacing%0d: got %0d cycles want 8", i, got_t[i] - got_t[i-1]); end
        end
        stop_capture();
    endtask

    task automatic test_saturation();
        got_q.delete(); smp_q.delete();
        start_capture(4000, 0, 1, 1'b0);
        for (int i = 0; i < 4000; i++) feed(14'h3FFF, 1'b1);
        for (int i = 0; i < 4000; i++) feed(14'h0000, 1'b1);
        idle_cycles(8);
        checks++;
        if (got_q.size() !== 1) begin errors++; $display("FAIL sat_count: got %0d beats want 1", got_q.size()); end
        else if (got_q[0] !== {1'b1, 16'h8000, 16'h7FFF}) begin
            errors++; $display("FAIL sat_data: got %h want %h", got_q[0], {1'b1, 16'h8000, 16'h7FFF});
        end
        stop_capture();
    endtask

    task automatic test_random();
        int r, sh, fl;
        for (int round = 0; round < 6; round++) begin
            got_q.delete(); smp_q.delete();
            r  = $urandom_range(6, 2);
            sh = $urandom_range(4, 0);
            fl = $urandom_range(4, 1);
            start_capture(r, sh, fl, 1'b0);
            rnd_ready = 1'b1;
            for (int i = 0; i < 80; i++) feed($urandom_range(16383, 0), ($urandom % 4) != 0);
            rnd_ready = 1'b0;
            M_AXIS_tready = 1'b1;
            idle_cycles(20);
            model_build(r, sh, fl, 1'b0);
            checks++;
            if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", round, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", round, i, got_q[i], exp_q[i]); end
            end
            checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL rand%0d_overflow: got %b want 0", round, Overflow); end
            stop_capture();
        end
    endtask

    // A push into a full FIFO is accepted when a pop happens in the same cycle
    task automatic test_full_push_pop();
        got_q.delete(); smp_q.delete();
        M_AXIS_tready = 1'b0;
        start_capture(1, 0, 8, 1'b0);
        for (int i = 0; i < 10; i++) feed(100 + i * 37, 1'b1);
        ADC_valid     = 1'b0;
        M_AXIS_tready = 1'b1;
        @(posedge aclk); #1;
        M_AXIS_tready = 1'b0;
        idle_cycles(3);
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b want 0", Overflow); end
        checks++; if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL fpp_tvalid: got %b want 1", M_AXIS_tvalid); end
        M_AXIS_tready = 1'b1;
        idle_cycles(8);
        model_build(1, 0, 8, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL fpp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        stop_capture();
    endtask

    task automatic test_overflow();
        got_q.delete(); smp_q.delete();
        hold_checks = 0;
        hold_viol   = 0;
        M_AXIS_tready = 1'b0;
        start_capture(1, 0, 3, 1'b0);
        for (int i = 0; i < 12; i++) feed(500 + i * 613, 1'b1);
        idle_cycles(3);
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
        checks++; if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL ovf_tvalid: got %b want 1", M_AXIS_tvalid); end
        M_AXIS_tready = 1'b1;
        idle_cycles(8);
        for (int i = 0; i < 6; i++) feed(9000 + i * 211, 1'b1);
        idle_cycles(10);
        model_build(1, 0, 3, 1'b0);
        // Beats 5 and 6 found the FIFO full
        exp_q.delete(5);
        exp_q.delete(4);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", hold_viol); end
        checks++; if (!(hold_checks > 0)) begin errors++; $display("FAIL stall_observed: got %0d stalled cycles want >0", hold_checks); end
        stop_capture();
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
    endtask

    task automatic test_single_shot();
        got_q.delete(); smp_q.delete();
        M_AXIS_tready = 1'b1;
        start_capture(1, 0, 2, 1'b1);
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ss_ovf_clear: got %b want 0", Overflow); end
        for (int i = 0; i < 16; i++) feed(1000 + i * 577, 1'b1);
        idle_cycles(8);
        checks++; if (ADC_sleep !== 1'b1) begin errors++; $display("FAIL ss_done_sleep: got %b want 1", ADC_sleep); end
        model_build(1, 0, 2, 1'b1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ss_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ss_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        stop_capture();
        got_q.delete(); smp_q.delete();
        start_capture(1, 0, 2, 1'b1);
        checks++; if (ADC_sleep !== 1'b0) begin errors++; $display("FAIL ss_restart_sleep: got %b want 0", ADC_sleep); end
        for (int i = 0; i < 4; i++) feed(15000 - i * 999, 1'b1);
        idle_cycles(8);
        model_build(1, 0, 2, 1'b1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ss2_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ss2_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        stop_capture();
    endtask

    task automatic test_abort();
        got_q.delete(); smp_q.delete();
        start_capture(2, 0, 4, 1'b0);
        for (int i = 0; i < 3; i++) feed(4000 + i * 100, 1'b1);
        stop_capture();
        idle_cycles(3);
        smp_q.delete();
        start_capture(2, 0, 4, 1'b0);
        for (int i = 0; i < 4; i++) feed(12000 + i * 321, 1'b1);
        idle_cycles(8);
        model_build(2, 0, 4, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        stop_capture();
    endtask

    task automatic test_reset_mid_frame();
        got_q.delete(); smp_q.delete();
        M_AXIS_tready = 1'b0;
        start_capture(1, 0, 2, 1'b0);
        for (int i = 0; i < 3; i++) feed(7000 + i * 55, 1'b1);
        ADC_valid = 1'b0;
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL async_tvalid: got %b want 0", M_AXIS_tvalid); end
        checks++; if (M_AXIS_tdata !== 32'h0) begin errors++; $display("FAIL async_tdata: got %h want 0", M_AXIS_tdata); end
        checks++; if (ADC_sleep !== 1'b1) begin errors++; $display("FAIL async_sleep: got %b want 1", ADC_sleep); end
        ADC_control   = 4'b0000;
        M_AXIS_tready = 1'b1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        idle_cycles(4);
        smp_q.delete();
        start_capture(1, 0, 2, 1'b0);
        for (int i = 0; i < 4; i++) feed(2500 + i * 1234, 1'b1);
        idle_cycles(8);
        model_build(1, 0, 2, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        stop_capture();
    endtask

    initial begin
        test_reset();
        test_pack();
        test_midscale_stream();
        test_saturation();
        test_random();
        test_full_push_pop();
        test_overflow();
        test_single_shot();
        test_abort();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
